// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: a 2-entry skid buffer (HEAD/SKID) feeding the ALU, with operand forwarding.
// Optional feature macro: ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding with per-cycle capture.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [RADDR-1:0] in_rs1,
    input  logic [RADDR-1:0] in_rs2,
    input  logic [RADDR-1:0] in_rd,
    input  logic [3:0]       in_alu_ctrl,
    input  logic             in_a_pc,
    input  logic             in_b_imm,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic [RADDR-1:0] exm_rd,
    input  logic             exm_reg_write,
    input  logic [XLEN-1:0]  exm_result,
    input  logic [RADDR-1:0] mwb_rd,
    input  logic             mwb_reg_write,
    input  logic [XLEN-1:0]  mwb_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [XLEN-1:0]  store_data,
    output logic [RADDR-1:0] out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic [3:0]       alu_ctrl;
        logic             a_pc;
        logic             b_imm;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state, state_nx;
    entry_t head, skid, head_nx, skid_nx;
    entry_t head_cap, skid_cap, in_entry, in_cap;
    logic   acc, pop;

`ifdef ID_EX_FWD_EN
    // EX/MEM has priority over MEM/WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd(input logic [RADDR-1:0] src,
                                            input logic [XLEN-1:0]  stored);
        logic [XLEN-1:0] r;
        r = stored;
        if (src != '0) begin
            if (exm_reg_write && (exm_rd == src))
                r = exm_result;
            else if (mwb_reg_write && (mwb_rd == src))
                r = mwb_result;
        end
        return r;
    endfunction
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_rd, exm_reg_write, exm_result,
                          mwb_rd, mwb_reg_write, mwb_result, head.rs1, head.rs2};
`endif

    // Replace stored operand data with the currently forwarded value.
    function automatic entry_t capture(input entry_t e);
        entry_t r;
        r = e;
`ifdef ID_EX_FWD_EN
        r.rs1_data = fwd(e.rs1, e.rs1_data);
        r.rs2_data = fwd(e.rs2, e.rs2_data);
`endif
        return r;
    endfunction

    always_comb begin
        in_entry           = '0;
        in_entry.pc        = in_pc;
        in_entry.rs1_data  = in_rs1_data;
        in_entry.rs2_data  = in_rs2_data;
        in_entry.imm       = in_imm;
        in_entry.rs1       = in_rs1;
        in_entry.rs2       = in_rs2;
        in_entry.rd        = in_rd;
        in_entry.alu_ctrl  = in_alu_ctrl;
        in_entry.a_pc      = in_a_pc;
        in_entry.b_imm     = in_b_imm;
        in_entry.reg_write = in_reg_write;
        in_entry.mem_read  = in_mem_read;
        in_entry.mem_write = in_mem_write;
    end

    assign in_cap   = capture(in_entry);
    assign head_cap = capture(head);
    assign skid_cap = capture(skid);

    assign acc = in_valid & in_ready;
    assign pop = (state != S_EMPTY) & out_ready;

    // State register, entry storage and registered in_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_EMPTY;
            in_ready <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != S_TWO);
            head     <= head_nx;
            skid     <= skid_nx;
        end
    end

    // Next state and next entry contents; valid entries recapture forwarded data every cycle.
    always_comb begin
        state_nx = state;
        head_nx  = head;
        skid_nx  = skid;
        case (state)
            S_EMPTY: begin
                if (acc) begin
                    state_nx = S_ONE;
                    head_nx  = in_cap;
                end
            end
            S_ONE: begin
                head_nx = head_cap;
                if (acc && pop) begin
                    head_nx = in_cap;
                end else if (acc) begin
                    state_nx = S_TWO;
                    skid_nx  = in_cap;
                end else if (pop) begin
                    state_nx = S_EMPTY;
                end
            end
            S_TWO: begin
                head_nx = head_cap;
                skid_nx = skid_cap;
                if (pop) begin
                    state_nx = S_ONE;
                    head_nx  = skid_cap;
                end
            end
            default: state_nx = S_EMPTY;
        endcase
        if (flush)
            state_nx = S_EMPTY;
    end

    // Head-driven outputs; downstream controls are gated when nothing is valid.
    always_comb begin
        out_valid     = (state != S_EMPTY);
        alu_a         = head.a_pc ? head.pc : head_cap.rs1_data;
        alu_b         = head.b_imm ? head.imm : head_cap.rs2_data;
        alu_ctrl      = head.alu_ctrl;
        store_data    = head_cap.rs2_data;
        out_rd        = head.rd;
        out_reg_write = out_valid & head.reg_write;
        out_mem_read  = out_valid & head.mem_read;
        out_mem_write = out_valid & head.mem_write;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the ID_EX_FWD_EN build setting.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_alu_ctrl;
    logic        in_a_pc, in_b_imm, in_reg_write, in_mem_read, in_mem_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_ctrl(in_alu_ctrl),
        .in_a_pc(in_a_pc), .in_b_imm(in_b_imm), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic a_pc, input logic b_imm, input logic [3:0] ctrl,
                         input logic rw, input logic mw);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1_data  = rs1d;
        in_rs2_data  = rs2d;
        in_imm       = imm;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = 5'd7;
        in_a_pc      = a_pc;
        in_b_imm     = b_imm;
        in_alu_ctrl  = ctrl;
        in_reg_write = rw;
        in_mem_read  = 1'b0;
        in_mem_write = mw;
    endtask

    task automatic clear_fwd();
        exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
        mwb_rd = '0; mwb_reg_write = 1'b0; mwb_result = '0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
        in_valid = 1'b0;
        clear_fwd();
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_reg_write", 32'(out_reg_write), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // basic latency and operand selection
        drive(32'h0, 32'd5, 32'd0, 32'd7, 5'd1, 5'd2, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_alu_a", alu_a, 32'd5);
        check("t1_alu_b", alu_b, 32'd7);
        check("t1_alu_ctrl", 32'(alu_ctrl), 32'b0010);
        check("t1_out_rd", 32'(out_rd), 32'd7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_popped", 32'(out_valid), 32'd0);

        // backpressure: two accepted, third held off until drained
        drive(0, 32'd100, 32'd0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0, 0);
        step();
        drive(0, 32'd101, 32'd0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0, 0);
        check("t2_ready_before_2nd", 32'(in_ready), 32'd1);
        step();
        check("t2_ready_after_2nd", 32'(in_ready), 32'd0);
        drive(0, 32'd102, 32'd0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0, 0);
        out_ready = 1'b1;
        #1;
        check("t2_head0", alu_a, 32'd100);
        step();
        check("t2_head1", alu_a, 32'd101);
        check("t2_ready_reopen", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t2_head2", alu_a, 32'd102);
        check("t2_valid2", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b0;
        check("t2_drained", 32'(out_valid), 32'd0);

        // forwarding priority and x0 exclusion
        drive(0, 32'h11, 32'h0, 0, 5'd3, 5'd0, 0, 1, 4'd0, 0, 0);
        step();
        in_valid = 1'b0;
        exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'hAA;
        mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'hBB;
        #1;
        check("t3_exm_wins", alu_a, FWD ? 32'hAA : 32'h11);
        exm_reg_write = 1'b0;
        #1;
        check("t3_mwb_only", alu_a, FWD ? 32'hBB : 32'h11);
        clear_fwd();
        #1;
        check("t3_no_fwd", alu_a, 32'h11);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(0, 32'h55, 32'h0, 0, 5'd0, 5'd0, 0, 1, 4'd0, 0, 0);
        exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hAA;
        step();
        in_valid = 1'b0;
        check("t3_x0_kept", alu_a, 32'h55);
        clear_fwd();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // capture of a producer that retires while the head stalls
        drive(0, 32'h0, 32'h9, 32'h3, 5'd0, 5'd4, 0, 1, 4'd0, 0, 1);
        step();
        in_valid = 1'b0;
        mwb_rd = 5'd4; mwb_reg_write = 1'b1; mwb_result = 32'h1234;
        step();
        clear_fwd();
        #1;
        check("t4_store_cap1", store_data, FWD ? 32'h1234 : 32'h9);
        step();
        check("t4_store_cap2", store_data, FWD ? 32'h1234 : 32'h9);
        check("t4_alu_b_imm", alu_b, 32'h3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // flush in state TWO with a concurrent input
        drive(0, 32'h200, 0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 1, 0);
        step();
        drive(0, 32'h201, 0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 1, 0);
        step();
        check("t5_full", 32'(in_ready), 32'd0);
        drive(0, 32'h202, 0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 1, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t5_flush_valid", 32'(out_valid), 32'd0);
        check("t5_flush_ready", 32'(in_ready), 32'd1);
        check("t5_flush_rw_gated", 32'(out_reg_write), 32'd0);
        drive(32'h400, 32'h203, 0, 0, 5'd0, 5'd0, 1, 0, 4'd5, 1, 1);
        step();
        in_valid = 1'b0;
        check("t5_first_after", 32'(out_valid), 32'd1);
        check("t5_alu_a_pc", alu_a, 32'h400);
        check("t5_mem_write", 32'(out_mem_write), 32'd1);
        check("t5_reg_write", 32'(out_reg_write), 32'd1);

        // reset while holding one entry
        reset = 1'b1;
        step();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_rw", 32'(out_reg_write), 32'd0);
        check("t6_rst_alu_a", alu_a, 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        step();
        check("t6_ready_after", 32'(in_ready), 32'd1);
        check("t6_valid_after", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
